// File: rtl/interrupt_request_and_service.sv
// 8-level interrupt request latch, rotating-priority resolver and in-service register.
// Optional IRQ_SYNC_EN adds a two-flop synchronizer in front of every IR pin.
module interrupt_request_and_service (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt_request_pin,
  input  logic       level_or_edge_toriggered_config,
  input  logic       special_fully_nest_config,
  input  logic       freeze,
  input  logic [7:0] clear_interrupt_request,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] interrupt_special_mask,
  input  logic [2:0] priority_rotate,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
  output logic [7:0] interrupt,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] in_service_register
);

  logic [7:0] ir_s;
  logic [7:0] edge_arm;
  logic [7:0] irr_next;
  logic [3:0] cand_rank;
  logic [3:0] isr_rank;
  logic [7:0] resolved;

  // Rank 0 is the level just above priority_rotate; 8 means no bit set.
  function automatic logic [3:0] first_rank(input logic [7:0] v, input logic [2:0] rot);
    logic [3:0] k;
    k = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (v[rot + 3'(i) + 3'd1]) k = 4'(i);
    return k;
  endfunction

  function automatic logic [7:0] rank_to_bit(input logic [3:0] k, input logic [2:0] rot);
    logic [7:0] b;
    b = '0;
    if (!k[3]) b[rot + k[2:0] + 3'd1] = 1'b1;
    return b;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [7:0] sync_p0;
  logic [7:0] sync_p1;

  // Synchronizer stages p0 -> p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= interrupt_request_pin;
      sync_p1 <= sync_p0;
    end
  end

  assign ir_s = sync_p1;
`else
  assign ir_s = interrupt_request_pin;
`endif

  // Edge requests need a prior low; an edge seen during freeze stays armed until released.
  always_comb begin
    if (level_or_edge_toriggered_config)
      irr_next = freeze ? interrupt_request_register : ir_s;
    else
      irr_next = interrupt_request_register | (ir_s & edge_arm & {8{~freeze}});
    irr_next = irr_next & ~clear_interrupt_request;
  end

  // Only the top-ranked candidate matters: if it is blocked, every lower one is too.
  always_comb begin
    cand_rank = first_rank(interrupt_request_register & ~interrupt_mask, priority_rotate);
    isr_rank  = first_rank(in_service_register & ~interrupt_special_mask, priority_rotate);
    resolved  = '0;
    if (!cand_rank[3] &&
        ((cand_rank < isr_rank) || ((cand_rank == isr_rank) && special_fully_nest_config)))
      resolved = rank_to_bit(cand_rank, priority_rotate);
  end

  assign highest_level_in_service = rank_to_bit(isr_rank, priority_rotate);

  // Request / service state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interrupt_request_register <= '0;
      edge_arm                   <= '0;
      in_service_register        <= '0;
      interrupt                  <= '0;
    end else begin
      interrupt_request_register <= irr_next;
      edge_arm                   <= ~ir_s | (edge_arm & {8{freeze}});
      in_service_register        <= (in_service_register & ~end_of_interrupt) |
                                    (latch_in_service ? interrupt : 8'h00);
      if (!freeze) interrupt <= resolved;
    end
  end

endmodule
